// File: rtl/huffman_table_builder.sv
// rtl/huffman_table_builder.sv - canonical Huffman symbol table builder from a code-length list
module huffman_table_builder #(
    parameter int SYM_BIT      = 9,
    parameter int LEN_BIT      = 4,
    parameter int MAX_LEN      = 15,
    parameter int SYM_COUNT    = 288,
    parameter int LEN_ADDR_BIT = 9,
    parameter int TAB_ADDR_BIT = 9,
    parameter int MARK_SYM     = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic [LEN_ADDR_BIT-1:0]    len_addr,
    output logic                       len_en,
    input  logic [SYM_BIT+LEN_BIT-1:0] len_data,
    output logic                       tab_we,
    output logic [TAB_ADDR_BIT-1:0]    tab_addr,
    output logic [SYM_BIT-1:0]         tab_sym,
    output logic [MAX_LEN-1:0]         tab_code,
    output logic [LEN_BIT-1:0]         tab_len,
    output logic                       busy,
    output logic                       done,
    output logic                       err_over,
    output logic                       mark_found,
    output logic [MAX_LEN-1:0]         mark_code,
    output logic [LEN_BIT-1:0]         mark_len
);
    localparam int CW = MAX_LEN + 1;
    localparam int IW = LEN_ADDR_BIT + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_CALC,
        S_ASSIGN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [LEN_BIT-1:0]      lsel_q, lsel_d;
    logic [CW-1:0]           code_q, code_d;
    logic signed [CW:0]      left_q, left_d;
    logic [TAB_ADDR_BIT-1:0] off_q, off_d;
    logic [CW-1:0]           bl_count_q [0:MAX_LEN];
    logic [CW-1:0]           bl_count_d [0:MAX_LEN];
    logic [CW-1:0]           next_code_q [0:MAX_LEN];
    logic [CW-1:0]           next_code_d [0:MAX_LEN];
    logic [TAB_ADDR_BIT-1:0] offset_q [0:MAX_LEN];
    logic [TAB_ADDR_BIT-1:0] offset_d [0:MAX_LEN];
    logic                    err_over_q, err_over_d;
    logic                    mark_found_q, mark_found_d;
    logic [MAX_LEN-1:0]      mark_code_q, mark_code_d;
    logic [LEN_BIT-1:0]      mark_len_q, mark_len_d;

    logic [LEN_BIT-1:0]      rd_len;
    logic [SYM_BIT-1:0]      rd_sym;
    logic                    rd_bad;
    logic                    rd_take;
    logic                    rd_last;
    logic [LEN_BIT-1:0]      lprev;

    assign rd_len  = len_data[LEN_BIT-1:0];
    assign rd_sym  = len_data[SYM_BIT+LEN_BIT-1:LEN_BIT];
    assign rd_take = rd_valid_q && (rd_len != '0) && !rd_bad;
    assign rd_last = (idx_q == IW'(SYM_COUNT));
    assign lprev   = lsel_q - LEN_BIT'(1);

    // The out-of-range length check only exists when the field can encode more than MAX_LEN.
    if (MAX_LEN < (1 << LEN_BIT) - 1) begin : g_len_chk
        assign rd_bad = (rd_len > LEN_BIT'(MAX_LEN));
    end else begin : g_no_len_chk
        assign rd_bad = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rd_valid_d   = 1'b0;
        lsel_d       = lsel_q;
        code_d       = code_q;
        left_d       = left_q;
        off_d        = off_q;
        bl_count_d   = bl_count_q;
        next_code_d  = next_code_q;
        offset_d     = offset_q;
        err_over_d   = err_over_q;
        mark_found_d = mark_found_q;
        mark_code_d  = mark_code_q;
        mark_len_d   = mark_len_q;
        len_en       = 1'b0;
        len_addr     = '0;
        tab_we       = 1'b0;
        tab_addr     = '0;
        tab_sym      = '0;
        tab_code     = '0;
        tab_len      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_COUNT;
                    idx_d        = '0;
                    lsel_d       = LEN_BIT'(1);
                    code_d       = '0;
                    left_d       = {{CW{1'b0}}, 1'b1};
                    off_d        = '0;
                    err_over_d   = 1'b0;
                    mark_found_d = 1'b0;
                    mark_code_d  = '0;
                    mark_len_d   = '0;
                    for (int i = 0; i <= MAX_LEN; i++) begin
                        bl_count_d[i] = '0;
                    end
                end
            end

            S_COUNT: begin
                if (!rd_last) begin
                    len_en     = 1'b1;
                    len_addr   = idx_q[LEN_ADDR_BIT-1:0];
                    idx_d      = idx_q + IW'(1);
                    rd_valid_d = 1'b1;
                end
                if (rd_valid_q && rd_bad) begin
                    err_over_d = 1'b1;
                end
                if (rd_take) begin
                    bl_count_d[rd_len] = bl_count_q[rd_len] + CW'(1);
                end
                if (rd_last) begin
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                // bl_count[0] is never incremented, so lsel=1 folds in a zero.
                code_d              = (code_q + bl_count_q[lprev]) << 1;
                next_code_d[lsel_q] = code_d;
                off_d               = off_q + TAB_ADDR_BIT'(bl_count_q[lprev]);
                offset_d[lsel_q]    = off_d;
                left_d              = (left_q <<< 1) - $signed({1'b0, bl_count_q[lsel_q]});
                if (left_d[CW]) begin
                    err_over_d = 1'b1;
                end
                if (lsel_q == LEN_BIT'(MAX_LEN)) begin
                    state_d = err_over_d ? S_DONE : S_ASSIGN;
                end else begin
                    lsel_d = lsel_q + LEN_BIT'(1);
                end
            end

            S_ASSIGN: begin
                if (!rd_last) begin
                    len_en     = 1'b1;
                    len_addr   = idx_q[LEN_ADDR_BIT-1:0];
                    idx_d      = idx_q + IW'(1);
                    rd_valid_d = 1'b1;
                end
                if (rd_take) begin
                    tab_we              = 1'b1;
                    tab_addr            = offset_q[rd_len];
                    tab_sym             = rd_sym;
                    tab_code            = next_code_q[rd_len][MAX_LEN-1:0];
                    tab_len             = rd_len;
                    offset_d[rd_len]    = offset_q[rd_len] + TAB_ADDR_BIT'(1);
                    next_code_d[rd_len] = next_code_q[rd_len] + CW'(1);
                    if (rd_sym == SYM_BIT'(MARK_SYM)) begin
                        mark_found_d = 1'b1;
                        mark_code_d  = next_code_q[rd_len][MAX_LEN-1:0];
                        mark_len_d   = rd_len;
                    end
                end
                if (rd_last) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            rd_valid_q   <= 1'b0;
            lsel_q       <= '0;
            code_q       <= '0;
            left_q       <= '0;
            off_q        <= '0;
            err_over_q   <= 1'b0;
            mark_found_q <= 1'b0;
            mark_code_q  <= '0;
            mark_len_q   <= '0;
            for (int i = 0; i <= MAX_LEN; i++) begin
                bl_count_q[i]  <= '0;
                next_code_q[i] <= '0;
                offset_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_valid_q   <= rd_valid_d;
            lsel_q       <= lsel_d;
            code_q       <= code_d;
            left_q       <= left_d;
            off_q        <= off_d;
            err_over_q   <= err_over_d;
            mark_found_q <= mark_found_d;
            mark_code_q  <= mark_code_d;
            mark_len_q   <= mark_len_d;
            bl_count_q   <= bl_count_d;
            next_code_q  <= next_code_d;
            offset_q     <= offset_d;
        end
    end

    assign busy       = (state_q == S_COUNT) || (state_q == S_CALC) || (state_q == S_ASSIGN);
    assign done       = (state_q == S_DONE);
    assign err_over   = err_over_q;
    assign mark_found = mark_found_q;
    assign mark_code  = mark_code_q;
    assign mark_len   = mark_len_q;
endmodule

// File: tb/tb_huffman_table_builder.sv
// tb/tb_huffman_table_builder.sv - randomized self-checking bench for huffman_table_builder
module tb_huffman_table_builder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic s_start = 1'b0, f_start = 1'b0;
    logic [8:0]  s_len_addr, f_len_addr, s_tab_addr, f_tab_addr, s_tab_sym, f_tab_sym;
    logic        s_len_en, f_len_en, s_tab_we, f_tab_we;
    logic [12:0] s_len_data = '0, f_len_data = '0;
    logic [14:0] s_tab_code, f_tab_code, s_mark_code, f_mark_code;
    logic [3:0]  s_tab_len, f_tab_len, s_mark_len, f_mark_len;
    logic        s_busy, f_busy, s_done, f_done, s_err_over, f_err_over, s_mark_found, f_mark_found;

    typedef struct { int addr; int sym; int code; int len; } wr_t;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  mem_len_s[512], mem_sym_s[512], mem_len_f[512], mem_sym_f[512];
    int  cyc = 0;
    int  n_checks = 0, n_fail = 0;
    int  lat, busy_cnt;
    int  exp_err, exp_mark_found, exp_mark_code, exp_mark_len, exp_lat;

    huffman_table_builder #(.SYM_COUNT(8), .MARK_SYM(7)) dut_s (
        .clock(clock), .reset(reset), .start(s_start),
        .len_addr(s_len_addr), .len_en(s_len_en), .len_data(s_len_data),
        .tab_we(s_tab_we), .tab_addr(s_tab_addr), .tab_sym(s_tab_sym),
        .tab_code(s_tab_code), .tab_len(s_tab_len),
        .busy(s_busy), .done(s_done), .err_over(s_err_over),
        .mark_found(s_mark_found), .mark_code(s_mark_code), .mark_len(s_mark_len)
    );

    huffman_table_builder dut_f (
        .clock(clock), .reset(reset), .start(f_start),
        .len_addr(f_len_addr), .len_en(f_len_en), .len_data(f_len_data),
        .tab_we(f_tab_we), .tab_addr(f_tab_addr), .tab_sym(f_tab_sym),
        .tab_code(f_tab_code), .tab_len(f_tab_len),
        .busy(f_busy), .done(f_done), .err_over(f_err_over),
        .mark_found(f_mark_found), .mark_code(f_mark_code), .mark_len(f_mark_len)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (s_len_en) s_len_data <= {9'(mem_sym_s[s_len_addr]), 4'(mem_len_s[s_len_addr])};
        if (f_len_en) f_len_data <= {9'(mem_sym_f[f_len_addr]), 4'(mem_len_f[f_len_addr])};
    end

    // Canonical code model: walk entries sorted by (length, RAM order); each code is the
    // previous code plus one, shifted left by the length step. Kraft sum decides over-subscription.
    task automatic model(input bit big);
        int n, mark, kraft, addr, c, prevl;
        int lens[512];
        int syms[512];
        int ea[512];
        int ec[512];
        bit first;
        wr_t w;
        n = big ? 288 : 8;
        mark = big ? 256 : 7;
        kraft = 0;
        for (int i = 0; i < n; i++) begin
            lens[i] = big ? mem_len_f[i] : mem_len_s[i];
            syms[i] = big ? mem_sym_f[i] : mem_sym_s[i];
            if (lens[i] != 0) kraft += 1 << (15 - lens[i]);
        end
        exp_err = (kraft > (1 << 15)) ? 1 : 0;
        exp_mark_found = 0;
        exp_mark_code = 0;
        exp_mark_len = 0;
        exp_q.delete();
        if (exp_err == 0) begin
            addr = 0; c = 0; prevl = 0; first = 1'b1;
            for (int l = 1; l <= 15; l++) begin
                for (int i = 0; i < n; i++) begin
                    if (lens[i] == l) begin
                        c = first ? 0 : ((c + 1) << (l - prevl));
                        first = 1'b0;
                        prevl = l;
                        ea[i] = addr;
                        ec[i] = c;
                        addr++;
                    end
                end
            end
            for (int i = 0; i < n; i++) begin
                if (lens[i] != 0) begin
                    w.addr = ea[i]; w.sym = syms[i]; w.code = ec[i]; w.len = lens[i];
                    exp_q.push_back(w);
                    if (syms[i] == mark) begin
                        exp_mark_found = 1; exp_mark_code = ec[i]; exp_mark_len = lens[i];
                    end
                end
            end
        end
        exp_lat = (exp_err != 0) ? (n + 1 + 15 + 1) : (2 * (n + 1) + 15 + 1);
    endtask

    // Starts one run, optionally re-pulsing start or asserting reset at a cycle offset.
    task automatic run(input bit big, input int extra_at, input int reset_at);
        int st;
        wr_t w;
        got_q.delete();
        lat = -1;
        busy_cnt = 0;
        @(negedge clock);
        if (big) f_start = 1'b1; else s_start = 1'b1;
        st = cyc;
        for (int k = 1; k < 3000; k++) begin
            @(negedge clock);
            s_start = 1'b0;
            f_start = 1'b0;
            if (k == extra_at) begin
                if (big) f_start = 1'b1; else s_start = 1'b1;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            if (big ? f_tab_we : s_tab_we) begin
                w.addr = big ? int'(f_tab_addr) : int'(s_tab_addr);
                w.sym  = big ? int'(f_tab_sym)  : int'(s_tab_sym);
                w.code = big ? int'(f_tab_code) : int'(s_tab_code);
                w.len  = big ? int'(f_tab_len)  : int'(s_tab_len);
                got_q.push_back(w);
            end
            if (big ? f_done : s_done) begin
                lat = cyc - st;
                break;
            end
            if (big ? f_busy : s_busy) busy_cnt++;
        end
    endtask

    task automatic load_rfc();
        int l[8];
        l = '{3, 3, 3, 3, 3, 2, 4, 4};
        for (int i = 0; i < 8; i++) begin
            mem_len_s[i] = l[i];
            mem_sym_s[i] = i;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({s_busy, s_done, s_tab_we, s_err_over, s_mark_found, s_len_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_s_flags: got %b expected 000000",
                     {s_busy, s_done, s_tab_we, s_err_over, s_mark_found, s_len_en});
        end
        n_checks++;
        if ({s_mark_code, s_mark_len, s_tab_addr, s_len_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_s_fields: mark_code %0d mark_len %0d tab_addr %0d len_addr %0d expected all 0",
                     s_mark_code, s_mark_len, s_tab_addr, s_len_addr);
        end
        n_checks++;
        if ({f_busy, f_done, f_tab_we, f_err_over, f_mark_found, f_len_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_f_flags: got %b expected 000000",
                     {f_busy, f_done, f_tab_we, f_err_over, f_mark_found, f_len_en});
        end
        reset = 1'b0;
    endtask

    task automatic test_rfc_example();
        int ea[8], ec[8], el[8];
        ea = '{1, 2, 3, 4, 5, 0, 6, 7};
        ec = '{2, 3, 4, 5, 6, 0, 14, 15};
        el = '{3, 3, 3, 3, 3, 2, 4, 4};
        load_rfc();
        run(1'b0, -1, -1);
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL rfc_latency: got %0d expected 34", lat); end
        n_checks++;
        if (busy_cnt !== 33) begin n_fail++; $display("FAIL rfc_busy_cycles: got %0d expected 33", busy_cnt); end
        n_checks++;
        if (got_q.size() !== 8) begin
            n_fail++;
            $display("FAIL rfc_write_count: got %0d expected 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got_q[i].sym !== i || got_q[i].addr !== ea[i] || got_q[i].code !== ec[i] || got_q[i].len !== el[i]) begin
                    n_fail++;
                    $display("FAIL rfc_write%0d: got sym %0d addr %0d code %0d len %0d expected sym %0d addr %0d code %0d len %0d",
                             i, got_q[i].sym, got_q[i].addr, got_q[i].code, got_q[i].len, i, ea[i], ec[i], el[i]);
                end
            end
        end
        n_checks++;
        if ({s_mark_found, s_err_over, s_mark_code, s_mark_len} !== {1'b1, 1'b0, 15'd15, 4'd4}) begin
            n_fail++;
            $display("FAIL rfc_mark: got found %0d err %0d code %0d len %0d expected found 1 err 0 code 15 len 4",
                     s_mark_found, s_err_over, s_mark_code, s_mark_len);
        end
        @(negedge clock);
        n_checks++;
        if ({s_done, s_busy, s_mark_found} !== 3'b001) begin
            n_fail++;
            $display("FAIL rfc_done_pulse: got done %0d busy %0d mark_found %0d expected 0 0 1", s_done, s_busy, s_mark_found);
        end
    endtask

    task automatic test_fixed_huffman();
        int bad;
        for (int i = 0; i < 288; i++) begin
            mem_sym_f[i] = i;
            mem_len_f[i] = (i < 144) ? 8 : (i < 256) ? 9 : (i < 280) ? 7 : 8;
        end
        model(1'b1);
        run(1'b1, -1, -1);
        n_checks++;
        if (lat !== 594) begin n_fail++; $display("FAIL fixed_latency: got %0d expected 594", lat); end
        n_checks++;
        if (got_q.size() !== 288) begin
            n_fail++;
            $display("FAIL fixed_write_count: got %0d expected 288", got_q.size());
        end else begin
            n_checks++;
            if (got_q[256].addr !== 0 || got_q[256].code !== 0 || got_q[256].len !== 7) begin
                n_fail++;
                $display("FAIL fixed_sym256: got addr %0d code %0d len %0d expected 0 0 7", got_q[256].addr, got_q[256].code, got_q[256].len);
            end
            n_checks++;
            if (got_q[0].addr !== 24 || got_q[0].code !== 'h30 || got_q[0].len !== 8) begin
                n_fail++;
                $display("FAIL fixed_sym0: got addr %0d code %0d len %0d expected 24 48 8", got_q[0].addr, got_q[0].code, got_q[0].len);
            end
            n_checks++;
            if (got_q[144].addr !== 176 || got_q[144].code !== 'h190 || got_q[144].len !== 9) begin
                n_fail++;
                $display("FAIL fixed_sym144: got addr %0d code %0d len %0d expected 176 400 9", got_q[144].addr, got_q[144].code, got_q[144].len);
            end
            bad = 0;
            for (int i = 0; i < 288; i++) if (got_q[i] != exp_q[i]) bad++;
            n_checks++;
            if (bad != 0) begin n_fail++; $display("FAIL fixed_table: got %0d wrong entries expected 0", bad); end
        end
        n_checks++;
        if ({f_mark_found, f_err_over, f_mark_code, f_mark_len} !== {1'b1, 1'b0, 15'd0, 4'd7}) begin
            n_fail++;
            $display("FAIL fixed_mark: got found %0d err %0d code %0d len %0d expected 1 0 0 7",
                     f_mark_found, f_err_over, f_mark_code, f_mark_len);
        end
    endtask

    task automatic test_oversubscribed();
        for (int i = 0; i < 8; i++) begin
            mem_len_s[i] = (i < 3) ? 1 : 0;
            mem_sym_s[i] = 7 - i;
        end
        run(1'b0, -1, -1);
        n_checks++;
        if (lat !== 25) begin n_fail++; $display("FAIL over_latency: got %0d expected 25", lat); end
        n_checks++;
        if (got_q.size() !== 0) begin n_fail++; $display("FAIL over_writes: got %0d expected 0", got_q.size()); end
        n_checks++;
        if ({s_err_over, s_mark_found} !== 2'b10) begin
            n_fail++;
            $display("FAIL over_flags: got err %0d mark_found %0d expected 1 0", s_err_over, s_mark_found);
        end
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 8; i++) begin
            mem_len_s[i] = 0;
            mem_sym_s[i] = 7;
        end
        run(1'b0, -1, -1);
        n_checks++;
        if (lat !== 34 || got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_run: got latency %0d writes %0d expected 34 0", lat, got_q.size());
        end
        n_checks++;
        if ({s_err_over, s_mark_found} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_flags: got err %0d mark_found %0d expected 0 0", s_err_over, s_mark_found);
        end
        load_rfc();
        model(1'b0);
        run(1'b0, -1, -1);
        n_checks++;
        if (lat !== exp_lat || got_q != exp_q || s_mark_code !== 15'(exp_mark_code)) begin
            n_fail++;
            $display("FAIL zero_rerun: got latency %0d writes %0d mark_code %0d expected %0d %0d %0d",
                     lat, got_q.size(), s_mark_code, exp_lat, exp_q.size(), exp_mark_code);
        end
    endtask

    task automatic test_start_during_calc();
        load_rfc();
        model(1'b0);
        run(1'b0, 15, -1);
        n_checks++;
        if (lat !== 34 || got_q != exp_q || s_mark_found !== 1'b1 || s_mark_len !== 4'(exp_mark_len)) begin
            n_fail++;
            $display("FAIL calc_start: got latency %0d writes %0d mark_found %0d mark_len %0d expected 34 %0d 1 %0d",
                     lat, got_q.size(), s_mark_found, s_mark_len, exp_q.size(), exp_mark_len);
        end
        repeat (5) @(negedge clock);
        n_checks++;
        if ({s_busy, s_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL calc_start_idle: got busy %0d done %0d expected 0 0", s_busy, s_done);
        end
    endtask

    task automatic test_reset_mid_assign();
        load_rfc();
        model(1'b0);
        run(1'b0, -1, 28);
        n_checks++;
        if ({s_tab_we, s_busy, s_done, s_err_over, s_mark_found, s_len_en, s_mark_code, s_mark_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got tab_we %0d busy %0d done %0d err %0d mark_found %0d len_en %0d mark_code %0d mark_len %0d expected all 0",
                     s_tab_we, s_busy, s_done, s_err_over, s_mark_found, s_len_en, s_mark_code, s_mark_len);
        end
        run(1'b0, -1, -1);
        n_checks++;
        if (lat !== exp_lat || got_q != exp_q || s_mark_code !== 15'(exp_mark_code)) begin
            n_fail++;
            $display("FAIL reset_restart: got latency %0d writes %0d mark_code %0d expected %0d %0d %0d",
                     lat, got_q.size(), s_mark_code, exp_lat, exp_q.size(), exp_mark_code);
        end
    endtask

    task automatic test_random();
        int mode, bad;
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 8; i++) begin
                mem_sym_s[i] = $urandom_range(0, 15);
                case (mode)
                    0: mem_len_s[i] = $urandom_range(0, 15);
                    1: mem_len_s[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 15);
                    default: mem_len_s[i] = $urandom_range(0, 4);
                endcase
            end
            model(1'b0);
            run(1'b0, -1, -1);
            bad = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] != exp_q[i]) bad++;
            n_checks++;
            if (lat !== exp_lat || got_q.size() !== exp_q.size() || bad != 0) begin
                n_fail++;
                $display("FAIL rand_s%0d_table: got latency %0d writes %0d bad %0d expected %0d %0d 0",
                         it, lat, got_q.size(), bad, exp_lat, exp_q.size());
            end
            n_checks++;
            if ({s_err_over, s_mark_found, s_mark_code, s_mark_len} !==
                {1'(exp_err), 1'(exp_mark_found), 15'(exp_mark_code), 4'(exp_mark_len)}) begin
                n_fail++;
                $display("FAIL rand_s%0d_status: got err %0d found %0d code %0d len %0d expected %0d %0d %0d %0d",
                         it, s_err_over, s_mark_found, s_mark_code, s_mark_len,
                         exp_err, exp_mark_found, exp_mark_code, exp_mark_len);
            end
        end
        for (int it = 0; it < 2; it++) begin
            for (int i = 0; i < 288; i++) begin
                mem_sym_f[i] = (i + 37 * it) % 512;
                mem_len_f[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(9, 15);
            end
            model(1'b1);
            run(1'b1, -1, -1);
            n_checks++;
            if (lat !== exp_lat || got_q != exp_q || f_err_over !== 1'(exp_err) ||
                f_mark_found !== 1'(exp_mark_found) || f_mark_code !== 15'(exp_mark_code)) begin
                n_fail++;
                $display("FAIL rand_f%0d: got latency %0d writes %0d err %0d found %0d code %0d expected %0d %0d %0d %0d %0d",
                         it, lat, got_q.size(), f_err_over, f_mark_found, f_mark_code,
                         exp_lat, exp_q.size(), exp_err, exp_mark_found, exp_mark_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rfc_example();
        test_fixed_huffman();
        test_oversubscribed();
        test_all_zero();
        test_start_during_calc();
        test_reset_mid_assign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
